// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the request encoder and its selectors.
// Provides the index and request-vector types and the output-state encoding.
package req_enc_pkg;

  localparam int NUM_SRC = 4;

  typedef logic [1:0]         idx_t;
  typedef logic [NUM_SRC-1:0] reqv_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_e;

  // One-hot mask for a source index.
  function automatic reqv_t idx_onehot(input idx_t idx);
    idx_onehot = reqv_t'(4'b0001) << idx;
  endfunction

endpackage

// File: rtl/req_encoder4x2_rr_pick4.sv
// Combinational 4-way selector: round-robin starting after ptr, or lowest index first.
// Reusable by other arbiters; found=0 means no candidate in pending.
module rr_pick4
  import req_enc_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  input  logic       rr_en,
  output logic       found,
  output logic [1:0] sel
);

  idx_t cand_s;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found  = 1'b0;
    sel    = 2'd0;
    cand_s = 2'd0;
    if (rr_en) begin
      for (int k = 4; k >= 1; k--) begin
        cand_s = ptr + k[1:0];
        if (pending[cand_s]) begin
          found = 1'b1;
          sel   = cand_s;
        end else begin
          found = found;
        end
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (pending[k]) begin
          found = 1'b1;
          sel   = k[1:0];
        end else begin
          found = found;
        end
      end
    end
  end

endmodule

// File: rtl/req_encoder4x2.sv
// Sequential 4-to-2 request encoder: captures request pulses into a pending set and
// serialises them as 2-bit indices over a registered valid/ready output.
module req_encoder4x2
  import req_enc_pkg::*;
#(
  parameter int RR_EN = 1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic [3:0] pending,
  output logic [3:0] overflow
);

  localparam logic RR_BIT = (RR_EN != 0) ? 1'b1 : 1'b0;

  out_state_e state_r, state_nxt_s;
  reqv_t      pending_r, pending_nxt_s;
  reqv_t      overflow_r, overflow_nxt_s;
  idx_t       idx_r, idx_nxt_s;
  idx_t       ptr_r, ptr_nxt_s;
  reqv_t      load_mask_s;
  logic       load_ok_s;
  logic       found_s;
  idx_t       sel_s;

  rr_pick4 u_pick (
    .pending (pending_r),
    .ptr     (ptr_r),
    .rr_en   (RR_BIT),
    .found   (found_s),
    .sel     (sel_s)
  );

  // Output slot may be (re)loaded when empty or when the held index is being taken.
  always_comb begin
    load_ok_s = 1'b0;
    case (state_r)
      EMPTY:   load_ok_s = 1'b1;
      HOLD:    load_ok_s = out_ready;
      default: load_ok_s = 1'b0;
    endcase
  end

  // Next-state, load mask, and capture of new pulses into the pending set.
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    ptr_nxt_s      = ptr_r;
    load_mask_s    = 4'b0000;
    if (load_ok_s && found_s) begin
      state_nxt_s = HOLD;
      idx_nxt_s   = sel_s;
      ptr_nxt_s   = sel_s;
      load_mask_s = idx_onehot(sel_s);
    end else if (load_ok_s) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
    // A pulse coinciding with its own load simply re-arms the bit; not a loss.
    pending_nxt_s  = (pending_r & ~load_mask_s) | req;
    overflow_nxt_s = overflow_r | (req & pending_r & ~load_mask_s);
  end

  // State and data registers; pointer resets to 3 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      idx_r      <= 2'd0;
      ptr_r      <= 2'd3;
      pending_r  <= 4'b0000;
      overflow_r <= 4'b0000;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      ptr_r      <= ptr_nxt_s;
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  assign out_valid = (state_r == HOLD);
  assign out_idx   = idx_r;
  assign pending   = pending_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_req_encoder4x2.sv
// Bench for req_encoder4x2: round-robin and fixed-priority instances share stimulus and
// are compared each cycle against an event-level reference model, plus directed checks.
module tb_req_encoder4x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rdy;
  logic       v0, v1;
  logic [1:0] i0, i1;
  logic [3:0] p0, p1, o0, o1;

  int n_vec = 0;
  int n_err = 0;

  // model state: index 0 = fixed priority, 1 = round robin
  logic [3:0] m_pend [2];
  logic [3:0] m_ovf  [2];
  bit         m_valid[2];
  int         m_idx  [2];
  int         m_ptr  [2];

  always #5 clk = ~clk;

  req_encoder4x2 #(.RR_EN(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(rdy),
    .out_valid(v0), .out_idx(i0), .pending(p0), .overflow(o0)
  );

  req_encoder4x2 #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(rdy),
    .out_valid(v1), .out_idx(i1), .pending(p1), .overflow(o1)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 4'b0000; m_ovf[u] = 4'b0000;
      m_valid[u] = 1'b0; m_idx[u] = 0; m_ptr[u] = 3;
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rd);
    for (int u = 0; u < 2; u++) begin
      logic [3:0] taken;
      int s;
      taken = 4'b0000;
      s = -1;
      if (!m_valid[u] || rd) begin
        for (int off = 1; off <= 4; off++) begin
          int c;
          c = (u == 1) ? (m_ptr[u] + off) % 4 : off - 1;
          if (s < 0 && m_pend[u][c]) s = c;
        end
        if (s >= 0) begin
          m_valid[u] = 1'b1; m_idx[u] = s; m_ptr[u] = s;
          taken[s] = 1'b1;
        end else begin
          m_valid[u] = 1'b0;
        end
      end
      m_ovf[u]  = m_ovf[u] | (r & m_pend[u] & ~taken);
      m_pend[u] = (m_pend[u] & ~taken) | r;
    end
  endtask

  task automatic check_all();
    chk("fix_valid", {3'b000, v0}, {3'b000, m_valid[0]});
    chk("fix_idx",   {2'b00, i0},  4'(m_idx[0]));
    chk("fix_pend",  p0,           m_pend[0]);
    chk("fix_ovf",   o0,           m_ovf[0]);
    chk("rr_valid",  {3'b000, v1}, {3'b000, m_valid[1]});
    chk("rr_idx",    {2'b00, i1},  4'(m_idx[1]));
    chk("rr_pend",   p1,           m_pend[1]);
    chk("rr_ovf",    o1,           m_ovf[1]);
  endtask

  task automatic step(input logic [3:0] r, input logic rd);
    req = r;
    rdy = rd;
    @(posedge clk);
    model_edge(r, rd);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    rdy   = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all();
      chk("rst_valid", {3'b000, v1}, 4'b0000);
    end
    rst_n = 1'b1;

    // held requests then first burst: 0,1,2,3 two edges after release
    step(4'b1111, 1'b1);
    chk("lat_valid_early", {3'b000, v1}, 4'b0000);
    step(4'b0000, 1'b1);
    chk("burst1_v", {3'b000, v1}, 4'b0001);
    chk("burst1_0", {2'b00, i1}, 4'd0);
    step(4'b0000, 1'b1); chk("burst1_1", {2'b00, i1}, 4'd1);
    step(4'b0000, 1'b1); chk("burst1_2", {2'b00, i1}, 4'd2);
    step(4'b0000, 1'b1); chk("burst1_3", {2'b00, i1}, 4'd3);
    step(4'b0000, 1'b1); chk("burst1_end", {3'b000, v1}, 4'b0000);

    // second burst after ptr=3
    step(4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, 1'b1);
      chk("burst2_idx", {2'b00, i1}, 4'(k));
    end
    step(4'b0000, 1'b1);

    // ptr=1 with pending 1011: 3,0,1
    step(4'b0010, 1'b1);
    step(4'b1011, 1'b1);
    chk("ptr1_load", {2'b00, i1}, 4'd1);
    chk("ptr1_pend", p1, 4'b1011);
    step(4'b0000, 1'b1); chk("ptr1_a", {2'b00, i1}, 4'd3);
    step(4'b0000, 1'b1); chk("ptr1_b", {2'b00, i1}, 4'd0);
    step(4'b0000, 1'b1); chk("ptr1_c", {2'b00, i1}, 4'd1);
    repeat (3) step(4'b0000, 1'b1);

    // fixed priority starvation of index 3 by re-pulsed index 1
    step(4'b1010, 1'b1);
    repeat (4) begin
      step(4'b0010, 1'b1);
      chk("fix_rep1", {2'b00, i0}, 4'd1);
    end
    step(4'b0000, 1'b1); chk("fix_last1", {2'b00, i0}, 4'd1);
    step(4'b0000, 1'b1); chk("fix_then3", {2'b00, i0}, 4'd3);
    repeat (6) step(4'b0000, 1'b1);

    // stalled output with double pulse on source 0
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    chk("hold_idx",  {2'b00, i0}, 4'd1);
    chk("hold_pend", p0, 4'b0001);
    chk("hold_ovf",  o0, 4'b0001);
    repeat (3) step(4'b0000, 1'b1);
    chk("ovf_sticky", o0, 4'b0001);

    // re-pulse on the loading edge of index 2
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    chk("reload_pend", p0, 4'b0100);
    chk("reload_ovf",  o0, 4'b0001);
    step(4'b0000, 1'b1);
    chk("reload_twice", {2'b00, i0}, 4'd2);
    step(4'b0000, 1'b1);
    chk("reload_done", {3'b000, v0}, 4'b0000);

    // asynchronous reset mid-operation
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", {3'b000, v1}, 4'b0000);
    chk("arst_pend",  p1, 4'b0000);
    chk("arst_ovf",   o0, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [3:0] r;
      r = 4'($urandom) & 4'($urandom);
      step(r, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
